// File: rtl/irig_pkg.sv
// Purpose: shared symbol codes, window percentages and MARK-tracker state for the IRIG front end.
// Latency: n/a (constants and a compile-time helper only).
// Backpressure: n/a.
package irig_pkg;

  // Symbol codes presented on the classifier's sym output.
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_MARK = 2'b10;

  // Window edges as a percentage of one bit period; each window is [lo, next lo).
  localparam int PCT_ZERO_LO = 10;
  localparam int PCT_ONE_LO  = 35;
  localparam int PCT_MARK_LO = 65;
  localparam int PCT_MARK_HI = 95;

  // MARK tracker: remembers whether the previous classified symbol was a MARK.
  typedef enum logic {
    TRK_IDLE      = 1'b0,
    TRK_PREV_MARK = 1'b1
  } trk_state_t;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/irig_input_filter.sv
// Purpose: 2-FF synchroniser plus FILT_LEN-sample glitch filter for the raw IRIG level.
// Latency: 2 + FILT_LEN cycles from pin to filtered level, identical for both edges.
// Backpressure: none; free-running, strobes are single-cycle.
// Ports: clk, rst_n (async, active-low); din raw level;
//        lvl filtered level; rise/fall 1-cycle strobes coincident with lvl changing.
module irig_input_filter
  import irig_pkg::*;
#(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int FCW = clog2(FILT_LEN + 1);

  logic           s1, s2;
  logic [1:0]     warm;
  logic           armed;
  logic [FCW-1:0] cnt;

  // warm marks when s2 holds a real pin sample rather than its reset value.
  // A rise only counts once the pin has been seen low after reset, so a
  // pulse already in progress at reset release never produces a rise strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      warm  <= 2'b00;
      armed <= 1'b0;
      cnt   <= '0;
      lvl   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      warm <= {warm[0], 1'b1};
      if (warm[1] && !s2) armed <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 != lvl) begin
        if (cnt + 1'b1 == FCW'(FILT_LEN)) begin
          lvl  <= s2;
          cnt  <= '0;
          rise <= s2 & armed;
          fall <= ~s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/irig_pulse_classifier.sv
// Purpose: measure each filtered IRIG high pulse, classify ZERO/ONE/MARK/ERROR, flag frame start and LOS.
// Latency: classification registered one cycle after the filtered falling edge.
// Backpressure: none; sym_valid/sym_err/frame_start are 1-cycle strobes the consumer must take.
// Ports: clk, rst_n (async, active-low); irig_in raw pin level;
//        sym_valid/sym_err strobes; sym code (held); width of last pulse;
//        frame_start on the 2nd consecutive MARK; los level.
module irig_pulse_classifier
  import irig_pkg::*;
#(
  parameter int CLK_HZ   = 10_000_000,
  parameter int BIT_HZ   = 100,
  parameter int FILT_LEN = 8,
  parameter int CNT_W    = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             irig_in,
  output logic             sym_valid,
  output logic [1:0]       sym,
  output logic             sym_err,
  output logic [CNT_W-1:0] width,
  output logic             frame_start,
  output logic             los
);

  localparam int BIT_CYC = CLK_HZ / BIT_HZ;
  localparam logic [CNT_W-1:0] W_ZERO_LO = CNT_W'(PCT_ZERO_LO * BIT_CYC / 100);
  localparam logic [CNT_W-1:0] W_ONE_LO  = CNT_W'(PCT_ONE_LO  * BIT_CYC / 100);
  localparam logic [CNT_W-1:0] W_MARK_LO = CNT_W'(PCT_MARK_LO * BIT_CYC / 100);
  localparam logic [CNT_W-1:0] W_MARK_HI = CNT_W'(PCT_MARK_HI * BIT_CYC / 100);
  localparam logic [CNT_W-1:0] LOS_LAST  = CNT_W'(2 * BIT_CYC - 1);

  logic             filt_lvl, rise, fall;
  logic [CNT_W-1:0] hi_cnt, per_cnt;
  logic             in_pulse;
  logic             classify, is_zero, is_one, is_mark, cls_vld, cls_err;
  logic [1:0]       cls_sym;
  logic             los_set, los_clr_trk, fs_d;
  trk_state_t       trk_q, trk_d;

  irig_input_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (irig_in),
    .lvl   (filt_lvl),
    .rise  (rise),
    .fall  (fall)
  );

  // hi_cnt counts filtered-high cycles, so at the fall strobe it holds the exact width.
  // in_pulse gates classification to pulses whose rising edge was seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt   <= '0;
      per_cnt  <= '0;
      in_pulse <= 1'b0;
      los      <= 1'b0;
    end else begin
      if (rise)                        hi_cnt <= CNT_W'(1);
      else if (filt_lvl && hi_cnt != '1) hi_cnt <= hi_cnt + 1'b1;

      if (rise)                per_cnt <= '0;
      else if (per_cnt != '1)  per_cnt <= per_cnt + 1'b1;

      if (rise)       in_pulse <= 1'b1;
      else if (fall)  in_pulse <= 1'b0;

      if (rise)          los <= 1'b0;
      else if (los_set)  los <= 1'b1;
    end
  end

  always_comb begin
    los_set     = !rise && !los && (per_cnt == LOS_LAST);
    los_clr_trk = los_set || los;
    classify    = fall && in_pulse;
    is_zero     = (hi_cnt >= W_ZERO_LO) && (hi_cnt < W_ONE_LO);
    is_one      = (hi_cnt >= W_ONE_LO)  && (hi_cnt < W_MARK_LO);
    is_mark     = (hi_cnt >= W_MARK_LO) && (hi_cnt < W_MARK_HI);
    cls_vld     = classify && (is_zero || is_one || is_mark);
    cls_err     = classify && !(is_zero || is_one || is_mark);
    cls_sym     = is_mark ? SYM_MARK : (is_one ? SYM_ONE : SYM_ZERO);
  end

  // MARK tracker: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trk_q <= TRK_IDLE;
    else        trk_q <= trk_d;
  end

  // MARK tracker: next state. Loss of signal overrides any symbol in the same cycle.
  always_comb begin
    trk_d = trk_q;
    if (los_clr_trk)    trk_d = TRK_IDLE;
    else if (classify)  trk_d = (cls_vld && is_mark) ? TRK_PREV_MARK : TRK_IDLE;
  end

  // MARK tracker: output.
  always_comb begin
    fs_d = cls_vld && is_mark && (trk_q == TRK_PREV_MARK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_valid   <= 1'b0;
      sym_err     <= 1'b0;
      sym         <= SYM_ZERO;
      width       <= '0;
      frame_start <= 1'b0;
    end else begin
      sym_valid   <= cls_vld;
      sym_err     <= cls_err;
      frame_start <= fs_d;
      if (classify) width <= hi_cnt;
      if (cls_vld)  sym   <= cls_sym;
    end
  end

endmodule

// File: tb/tb_irig_pulse_classifier.sv
// Purpose: directed bench for irig_pulse_classifier at a scaled clock (BIT_CYC = 1000).
// Latency: n/a.
// Backpressure: n/a.
module tb_irig_pulse_classifier;

  localparam int CNT_W = 12;
  localparam int LOS_CYC = 2000;

  typedef struct {
    logic             err;
    logic [1:0]       sym;
    logic [CNT_W-1:0] w;
    logic             fs;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             irig_in = 1'b0;
  logic             sym_valid, sym_err, frame_start, los;
  logic [1:0]       sym;
  logic [CNT_W-1:0] width;

  int  n_chk = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  los_rise_cyc = -1;
  logic los_q = 1'b0;
  ev_t evq[$];

  irig_pulse_classifier #(
    .CLK_HZ(100_000), .BIT_HZ(100), .FILT_LEN(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irig_in(irig_in),
    .sym_valid(sym_valid), .sym(sym), .sym_err(sym_err), .width(width),
    .frame_start(frame_start), .los(los)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sym_valid || sym_err || frame_start) begin
        ev_t e;
        e.err = sym_err & ~sym_valid;
        e.sym = sym;
        e.w   = width;
        e.fs  = frame_start;
        evq.push_back(e);
      end
      if (los && !los_q) los_rise_cyc = cyc;
      los_q = los;
    end else begin
      los_q = 1'b0;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    irig_in = 1'b1;
    repeat (hi) @(negedge clk);
    irig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic expect_ev(input string tag, input logic err, input logic [1:0] s,
                           input int w, input logic fs);
    ev_t e;
    chk({tag, "_present"}, 32'(evq.size() > 0), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk({tag, "_err"}, 32'(e.err), 32'(err));
      if (!err) chk({tag, "_sym"}, 32'(e.sym), 32'(s));
      chk({tag, "_width"}, 32'(e.w), w);
      chk({tag, "_fs"}, 32'(e.fs), 32'(fs));
    end
  endtask

  initial begin
    int rise_cyc;
    repeat (3) @(negedge clk);
    chk("rst_sym_valid", 32'(sym_valid), 0);
    chk("rst_sym", 32'(sym), 0);
    chk("rst_sym_err", 32'(sym_err), 0);
    chk("rst_width", 32'(width), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_los", 32'(los), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // ZERO
    pulse(200, 800);
    expect_ev("zero", 1'b0, 2'b00, 200, 1'b0);
    // ONE then MARK
    pulse(500, 500);
    expect_ev("one", 1'b0, 2'b01, 500, 1'b0);
    pulse(800, 200);
    expect_ev("mark", 1'b0, 2'b10, 800, 1'b0);
    // Too short, then too long: errors, sym held
    pulse(50, 950);
    expect_ev("short", 1'b1, 2'b00, 50, 1'b0);
    chk("sym_hold", 32'(sym), 2);
    pulse(970, 30);
    expect_ev("long", 1'b1, 2'b00, 970, 1'b0);
    // MARK, MARK, ONE
    pulse(800, 200);
    expect_ev("mm1", 1'b0, 2'b10, 800, 1'b0);
    pulse(800, 200);
    expect_ev("mm2", 1'b0, 2'b10, 800, 1'b1);
    pulse(500, 500);
    expect_ev("mm3", 1'b0, 2'b01, 500, 1'b0);
    chk("mm_empty", 32'(evq.size()), 0);

    // Low glitch inside a high pulse, then an isolated high spike
    pulse(100, 5);
    pulse(95, 400);
    expect_ev("glitch", 1'b0, 2'b00, 200, 1'b0);
    pulse(5, 500);
    chk("spike_empty", 32'(evq.size()), 0);

    // MARK, loss of signal, MARK
    rise_cyc = cyc;
    pulse(800, 1400);
    expect_ev("los_mark1", 1'b0, 2'b10, 800, 1'b0);
    chk("los_set", 32'(los), 1);
    chk("los_timing", los_rise_cyc - rise_cyc, LOS_CYC + 11);
    pulse(800, 200);
    expect_ev("los_mark2", 1'b0, 2'b10, 800, 1'b0);
    chk("los_clear", 32'(los), 0);

    // Reset in the middle of a pulse
    irig_in = 1'b1;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sym", 32'(sym), 0);
    chk("mid_rst_width", 32'(width), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    irig_in = 1'b0;
    repeat (600) @(negedge clk);
    chk("tail_empty", 32'(evq.size()), 0);
    pulse(500, 500);
    expect_ev("post_rst", 1'b0, 2'b01, 500, 1'b0);
    chk("end_empty", 32'(evq.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
